// File: rtl/multi_lane_compact_fifo_if.sv
// Handshake bundle for the multi-lane compacting dispatch FIFO.
// master: the decode/issue side driving requests; slave: the FIFO itself.
interface multi_lane_compact_fifo_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 16,
  parameter int unsigned EnqLanes  = 4,
  parameter int unsigned DeqLanes  = 2
);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PopW = $clog2(DeqLanes + 1);

  logic                          flush_i;
  logic [EnqLanes-1:0]           enq_valid_i;
  logic [EnqLanes*DataWidth-1:0] enq_data_i;
  logic                          enq_ready_o;
  logic [DeqLanes-1:0]           deq_valid_o;
  logic [DeqLanes*DataWidth-1:0] deq_data_o;
  logic [PopW-1:0]               deq_pop_i;
  logic [CntW-1:0]               count_o;
  logic                          empty_o;
  logic                          full_o;

  modport master (
    output flush_i, enq_valid_i, enq_data_i, deq_pop_i,
    input  enq_ready_o, deq_valid_o, deq_data_o, count_o, empty_o, full_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_data_i, deq_pop_i,
    output enq_ready_o, deq_valid_o, deq_data_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/multi_lane_compact_fifo.sv
// Compacting multi-lane FIFO: sparse enqueue mask packed into consecutive slots,
// up to DeqLanes oldest entries presented, variable clamped pop count.
module multi_lane_compact_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 16,
  parameter int unsigned EnqLanes  = 4,
  parameter int unsigned DeqLanes  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  multi_lane_compact_fifo_if.slave      busIf
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PopW = $clog2(DeqLanes + 1);

  logic [PtrW-1:0]      head;
  logic [PtrW-1:0]      tail;
  logic [CntW-1:0]      count;
  logic [DataWidth-1:0] mem [Depth];

  logic                 enqReady;
  logic                 enqFire;
  logic [CntW-1:0]      enqCnt;
  logic [CntW-1:0]      popEff;
  logic [CntW-1:0]      popLimit;
  logic [CntW-1:0]      prefix [EnqLanes+1];
  logic [PtrW-1:0]      slot   [EnqLanes];
  logic [PtrW-1:0]      rdAddr [DeqLanes];

  assign enqReady = (CntW'(Depth) - count) >= CntW'(EnqLanes);
  assign enqFire  = enqReady && (busIf.enq_valid_i != '0);

  // prefix[k] = number of valid lanes below k; gives each lane its packed slot offset
  always_comb begin
    prefix[0] = '0;
    for (int unsigned k = 0; k < EnqLanes; k++) begin
      prefix[k+1] = prefix[k] + CntW'(busIf.enq_valid_i[k]);
      slot[k]     = tail + prefix[k][PtrW-1:0];
    end
  end

  assign enqCnt = enqFire ? prefix[EnqLanes] : '0;

  // pop_eff = min(request, count, DeqLanes)
  always_comb begin
    popLimit = (count < CntW'(DeqLanes)) ? count : CntW'(DeqLanes);
    popEff   = (CntW'(busIf.deq_pop_i) < popLimit) ? CntW'(busIf.deq_pop_i) : popLimit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (busIf.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + popEff[PtrW-1:0];
      tail  <= tail + enqCnt[PtrW-1:0];
      count <= count + enqCnt - popEff;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < EnqLanes; k++) begin
      if (enqFire && !busIf.flush_i && busIf.enq_valid_i[k]) begin
        mem[slot[k]] <= busIf.enq_data_i[k*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < DeqLanes; j++) begin
      rdAddr[j]                                  = head + PtrW'(j);
      busIf.deq_valid_o[j]                       = count > CntW'(j);
      busIf.deq_data_o[j*DataWidth +: DataWidth] = mem[rdAddr[j]];
    end
  end

  assign busIf.enq_ready_o = enqReady;
  assign busIf.count_o     = count;
  assign busIf.empty_o     = (count == '0);
  assign busIf.full_o      = (count == CntW'(Depth));

  countBounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= CntW'(Depth));
  tailTracksHead: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tail == PtrW'(head + count[PtrW-1:0]));
  noEnqWhenBlocked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !enqReady |-> enqCnt == '0);
endmodule

// File: tb/tb_multi_lane_compact_fifo.sv
// Directed self-checking bench for multi_lane_compact_fifo (default parameters).
module tb_multi_lane_compact_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned EL    = 4;
  localparam int unsigned DL    = 2;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_lane_compact_fifo_if #(.DataWidth(DW), .Depth(DEPTH), .EnqLanes(EL), .DeqLanes(DL)) fifoBus ();

  multi_lane_compact_fifo #(.DataWidth(DW), .Depth(DEPTH), .EnqLanes(EL), .DeqLanes(DL)) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .busIf (fifoBus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifoBus.flush_i     = 1'b0;
    fifoBus.enq_valid_i = '0;
    fifoBus.enq_data_i  = '0;
    fifoBus.deq_pop_i   = '0;
  endtask

  task automatic drive(input logic [3:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3, input logic [1:0] pop);
    fifoBus.enq_valid_i = mask;
    fifoBus.enq_data_i  = {d3, d2, d1, d0};
    fifoBus.deq_pop_i   = pop;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifoBus.count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifoBus.count_o); end
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifoBus.empty_o); end
    checks++; if (fifoBus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifoBus.full_o); end
    checks++; if (fifoBus.enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fifoBus.enq_ready_o); end
    checks++; if (fifoBus.deq_valid_o !== 2'b00) begin errors++; $display("FAIL reset_deqvalid got %b exp 00", fifoBus.deq_valid_o); end
  endtask

  task automatic test_sparse_enq();
    do_reset();
    drive(4'b1010, 32'hFF, 32'hA1, 32'hEE, 32'hA3, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd2) begin errors++; $display("FAIL sparse_count got %0d exp 2", fifoBus.count_o); end
    checks++; if (fifoBus.deq_valid_o !== 2'b11) begin errors++; $display("FAIL sparse_deqvalid got %b exp 11", fifoBus.deq_valid_o); end
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'hA1) begin errors++; $display("FAIL sparse_lane0 got %h exp a1", fifoBus.deq_data_o[31:0]); end
    checks++; if (fifoBus.deq_data_o[63:32] !== 32'hA3) begin errors++; $display("FAIL sparse_lane1 got %h exp a3", fifoBus.deq_data_o[63:32]); end
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL sparse_drain_empty got %b exp 1", fifoBus.empty_o); end
  endtask

  task automatic test_ready_boundary();
    logic [31:0] e0, e1;
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(4'b1111, 32'h100 + 4*i, 32'h101 + 4*i, 32'h102 + 4*i, 32'h103 + 4*i, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd12) begin errors++; $display("FAIL rdy12_count got %0d exp 12", fifoBus.count_o); end
    checks++; if (fifoBus.enq_ready_o !== 1'b1) begin errors++; $display("FAIL rdy12_ready got %b exp 1", fifoBus.enq_ready_o); end
    drive(4'b0001, 32'h200, 32'h0, 32'h0, 32'h0, 2'd0);
    checks++; if (fifoBus.enq_ready_o !== 1'b0) begin errors++; $display("FAIL rdy13_ready got %b exp 0", fifoBus.enq_ready_o); end
    drive(4'b1111, 32'hBAD0, 32'hBAD1, 32'hBAD2, 32'hBAD3, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd13) begin errors++; $display("FAIL blocked_count got %0d exp 13", fifoBus.count_o); end
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'h100) begin errors++; $display("FAIL blocked_head got %h exp 100", fifoBus.deq_data_o[31:0]); end
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.count_o !== 5'd11) begin errors++; $display("FAIL pop_count got %0d exp 11", fifoBus.count_o); end
    checks++; if (fifoBus.enq_ready_o !== 1'b1) begin errors++; $display("FAIL pop_ready got %b exp 1", fifoBus.enq_ready_o); end
    for (int i = 0; i < 5; i++) begin
      e0 = 32'h102 + 2*i;
      e1 = 32'h103 + 2*i;
      checks++; if (fifoBus.deq_data_o[31:0] !== e0) begin errors++; $display("FAIL drain_lane0 got %h exp %h", fifoBus.deq_data_o[31:0], e0); end
      checks++; if (fifoBus.deq_data_o[63:32] !== e1) begin errors++; $display("FAIL drain_lane1 got %h exp %h", fifoBus.deq_data_o[63:32], e1); end
      drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    end
    checks++; if (fifoBus.deq_valid_o !== 2'b01) begin errors++; $display("FAIL last_deqvalid got %b exp 01", fifoBus.deq_valid_o); end
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'h200) begin errors++; $display("FAIL last_lane0 got %h exp 200", fifoBus.deq_data_o[31:0]); end
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL drained_empty got %b exp 1", fifoBus.empty_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", fifoBus.count_o); end
    checks++; if (fifoBus.full_o !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", fifoBus.full_o); end
    checks++; if (fifoBus.enq_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", fifoBus.enq_ready_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(4'b1111, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    drive(4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < 7; i++)
      drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL wrap_setup_empty got %b exp 1", fifoBus.empty_o); end
    drive(4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd4) begin errors++; $display("FAIL wrap_count got %0d exp 4", fifoBus.count_o); end
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'd1) begin errors++; $display("FAIL wrap_r0 got %0d exp 1", fifoBus.deq_data_o[31:0]); end
    checks++; if (fifoBus.deq_data_o[63:32] !== 32'd2) begin errors++; $display("FAIL wrap_r1 got %0d exp 2", fifoBus.deq_data_o[63:32]); end
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'd3) begin errors++; $display("FAIL wrap_r2 got %0d exp 3", fifoBus.deq_data_o[31:0]); end
    checks++; if (fifoBus.deq_data_o[63:32] !== 32'd4) begin errors++; $display("FAIL wrap_r3 got %0d exp 4", fifoBus.deq_data_o[63:32]); end
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", fifoBus.empty_o); end
  endtask

  task automatic test_clamp_and_simul();
    do_reset();
    drive(4'b0001, 32'h55, 32'h0, 32'h0, 32'h0, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd1) begin errors++; $display("FAIL clamp_pre_count got %0d exp 1", fifoBus.count_o); end
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    checks++; if (fifoBus.count_o !== 5'd0) begin errors++; $display("FAIL clamp_count got %0d exp 0", fifoBus.count_o); end
    checks++; if (fifoBus.deq_valid_o !== 2'b00) begin errors++; $display("FAIL clamp_deqvalid got %b exp 00", fifoBus.deq_valid_o); end
    drive(4'b0111, 32'h10, 32'h11, 32'h12, 32'h0, 2'd0);
    drive(4'b0011, 32'h20, 32'h21, 32'h0, 32'h0, 2'd1);
    checks++; if (fifoBus.count_o !== 5'd4) begin errors++; $display("FAIL simul_count got %0d exp 4", fifoBus.count_o); end
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'h11) begin errors++; $display("FAIL simul_lane0 got %h exp 11", fifoBus.deq_data_o[31:0]); end
    checks++; if (fifoBus.deq_data_o[63:32] !== 32'h12) begin errors++; $display("FAIL simul_lane1 got %h exp 12", fifoBus.deq_data_o[63:32]); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 2'd0);
    drive(4'b0111, 32'h5, 32'h6, 32'h7, 32'h0, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd7) begin errors++; $display("FAIL flush_pre_count got %0d exp 7", fifoBus.count_o); end
    fifoBus.flush_i = 1'b1;
    drive(4'b1111, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 2'd2);
    checks++; if (fifoBus.count_o !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", fifoBus.count_o); end
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", fifoBus.empty_o); end
    checks++; if (fifoBus.deq_valid_o !== 2'b00) begin errors++; $display("FAIL flush_deqvalid got %b exp 00", fifoBus.deq_valid_o); end
    drive(4'b0100, 32'h0, 32'h0, 32'h77, 32'h0, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd1) begin errors++; $display("FAIL post_flush_count got %0d exp 1", fifoBus.count_o); end
    checks++; if (fifoBus.deq_data_o[31:0] !== 32'h77) begin errors++; $display("FAIL post_flush_lane0 got %h exp 77", fifoBus.deq_data_o[31:0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 2'd0);
    drive(4'b0001, 32'h5, 32'h0, 32'h0, 32'h0, 2'd0);
    checks++; if (fifoBus.count_o !== 5'd5) begin errors++; $display("FAIL async_pre_count got %0d exp 5", fifoBus.count_o); end
    #2;
    rstN = 1'b0;
    #1;
    checks++; if (fifoBus.count_o !== 5'd0) begin errors++; $display("FAIL async_count got %0d exp 0", fifoBus.count_o); end
    checks++; if (fifoBus.empty_o !== 1'b1) begin errors++; $display("FAIL async_empty got %b exp 1", fifoBus.empty_o); end
    checks++; if (fifoBus.enq_ready_o !== 1'b1) begin errors++; $display("FAIL async_ready got %b exp 1", fifoBus.enq_ready_o); end
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b1;
    idle();
    #2;
    test_reset();
    test_sparse_enq();
    test_ready_boundary();
    test_full();
    test_wrap();
    test_clamp_and_simul();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_lane_compact_fifo.md
Name: multi_lane_compact_fifo

Overview:
- Multi-lane FIFO that accepts a sparse per-lane valid mask each cycle and writes the valid entries into consecutive slots in lane order.
- Presents up to DeqLanes oldest entries to the consumer each cycle, and the consumer pops a variable count.
- Sits directly downstream of the ones-counter: enqueue slot offsets and tail advance come from popcounts of the valid mask, and occupancy is tracked as a counter.
- Used as the dispatch/issue staging buffer between decode lanes and issue.

Parameters:
DataWidth, 32, payload bits per entry
Depth, 16, number of entries; power of two, >= EnqLanes, >= DeqLanes
EnqLanes, 4, enqueue lanes per cycle
DeqLanes, 2, dequeue lanes per cycle

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  discard all contents
enq_valid_i  input  EnqLanes  per-lane enqueue request mask (may be non-contiguous)
enq_data_i  input  EnqLanes*DataWidth  lane k payload at [k*DataWidth +: DataWidth]
enq_ready_o  output  1  all lanes may enqueue this cycle
deq_valid_o  output  DeqLanes  lane j holds the j-th oldest entry
deq_data_o  output  DeqLanes*DataWidth  lane j payload
deq_pop_i  input  $clog2(DeqLanes+1)  number of head entries consumed this cycle
count_o  output  $clog2(Depth+1)  current occupancy
empty_o  output  1  count_o == 0
full_o  output  1  count_o == Depth

Behaviour:
- State registers:
  - head and tail pointers, each $clog2(Depth) bits, wrapping modulo Depth.
  - count register, $clog2(Depth+1) bits.
  - storage array; not reset.
- Reset (rst_ni low, asynchronous):
  - head = tail = count = 0.
  - Resulting outputs: deq_valid_o = 0, enq_ready_o = 1, empty_o = 1, full_o = 0, count_o = 0.
  - Reset asserted mid-operation discards all contents immediately.
- enq_ready_o is derived from registered state only: (Depth - count) >= EnqLanes. It never depends on enq_valid_i or deq_pop_i in the same cycle.
- Enqueue fires when enq_ready_o is high and enq_valid_i is nonzero. Acceptance is all-or-nothing: every valid lane is written, or none is.
- Slot for valid lane k: tail + popcount(enq_valid_i[k-1:0]), modulo Depth.
- enq_cnt = popcount(enq_valid_i) when the enqueue fires, else 0. tail advances by enq_cnt.
- Lanes with enq_valid_i = 0 write nothing. When enq_ready_o is low, nothing is written regardless of enq_valid_i.
- Dequeue outputs:
  - deq_valid_o[j] = (count > j).
  - deq_data_o lane j = storage[head + j] modulo Depth.
  - Data on invalid lanes is don't-care.
- pop_eff = min(deq_pop_i, count, DeqLanes). Over-pop is clamped, never underflows. head advances by pop_eff.
- Occupancy: count_next = count + enq_cnt - pop_eff.
  - Simultaneous enqueue and dequeue are both honoured in the same cycle.
  - Entries enqueued in cycle N are visible on deq outputs from cycle N+1 (1-cycle latency, no bypass).
  - Slots freed by pop in cycle N count toward enq_ready_o from cycle N+1.
- Flush (flush_i high at a clock edge):
  - head, tail and count all return to 0.
  - Flush has priority: same-cycle enqueue and pop are ignored.
  - Outputs reflect the empty state in the next cycle.
- Ordering: entries leave in the order written. Within one enqueue cycle, lower lane index is older.
- Wrap-around: slot and head+j address arithmetic is performed modulo Depth. A lane group spanning the end of the array splits across the wrap seamlessly.
- Prefix popcounts: computed combinationally for each lane; no added pipeline stage.
- Invariants checked by assertions:
  - count <= Depth.
  - tail == head + count, modulo Depth.
  - No enqueue is written when enq_ready_o is low.

Test Plan:
- Reset then enq_valid_i=4'b1010 with data lane1=0xA1, lane3=0xA3 -> next cycle count_o=2, deq_valid_o=2'b11, deq_data lane0=0xA1, lane1=0xA3.
- Fill to count=12 (defaults) -> enq_ready_o=1; fill to count=13 -> enq_ready_o=0 and enq_valid_i=4'b1111 writes nothing, count stays 13; pop 2 -> next cycle count=11, enq_ready_o=1.
- head=14, tail=14, count=0; enqueue 4'b1111 data 1..4 -> entries land in slots 14,15,0,1; pop 2 then 2 -> read order 1,2 then 3,4; empty_o=1 afterwards.
- count=1, deq_pop_i=2 -> pop clamped to 1, count_o=0, no underflow; simultaneous enq 4'b0011 and pop 1 at count=3 -> count_o=4.
- count=7, flush_i=1 together with enq_valid_i=4'b1111 and deq_pop_i=2 -> next cycle count_o=0, empty_o=1, deq_valid_o=0, nothing written.
- Assert rst_ni low asynchronously between clock edges at count=5 -> outputs immediately show count_o=0, empty_o=1, enq_ready_o=1.
